// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - register offsets, STATUS bit indices and FSM encoding for blit_regs
// Shared by blit_regs and its bench; no dependence on BLIT_REGS_KBD_FIFO_EN.
package blit_pkg;

  localparam logic [7:0] REG_DSTART = 8'h00;
  localparam logic [7:0] REG_MOUSEX = 8'h02;
  localparam logic [7:0] REG_MOUSEY = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h06;
  localparam logic [7:0] REG_KBD    = 8'h08;
  localparam logic [7:0] REG_INTCTL = 8'h0A;

  localparam int ST_VBL    = 0;
  localparam int ST_KRDY   = 1;
  localparam int ST_KOVF   = 2;
  localparam int ST_BTN_LO = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  wstrb);
    logic [15:0] r;
    r = old;
    if (wstrb[0]) r[7:0]  = wdata[7:0];
    if (wstrb[1]) r[15:8] = wdata[15:8];
    return r;
  endfunction

endpackage

// File: rtl/blit_kbd_fifo.sv
// rtl/blit_kbd_fifo.sv - keyboard receive buffer
// BLIT_REGS_KBD_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single overwriting byte.
module blit_kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       ovf
);

`ifdef BLIT_REGS_KBD_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so a push into a full FIFO still lands that cycle
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
`else
  logic       valid_q;
  logic [7:0] data_q;

  assign empty = !valid_q;
  assign full  = valid_q;
  assign ovf   = push && valid_q && !pop;
  assign head  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/blit_regs.sv
// rtl/blit_regs.sv - CPU register responder: display start, mouse, keyboard, interrupts
// Keyboard buffer depth is chosen by BLIT_REGS_KBD_FIFO_EN (see blit_kbd_fifo).
module blit_regs
  import blit_pkg::*;
#(
  parameter int MOUSE_MAX = 1023,
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regs_req,
  input  logic [7:0]  regs_addr,
  input  logic [15:0] regs_wdata,
  input  logic [1:0]  regs_wstrb,
  input  logic        regs_we,
  output logic        regs_ack,
  output logic [15:0] regs_rdata,
  input  logic        mouse_valid,
  input  logic [7:0]  mouse_dx,
  input  logic [7:0]  mouse_dy,
  input  logic [2:0]  mouse_btn,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        vblank,
  output logic [15:0] display_start,
  output logic        irq
);

  state_t      state_q, state_d;
  logic [15:0] dstart_q, rdata_q, rd_mux, mx_merge, my_merge;
  logic [9:0]  mouse_x_q, mouse_y_q;
  logic [1:0]  irq_en_q;
  logic        vbl_q, kovf_q, pop_pend_q;
  logic [7:0]  addr, kbd_head;
  logic        take, wr, rd, kbd_empty, kbd_full, kbd_ovf;
  logic        unused_ok;

  function automatic logic [9:0] mouse_step(input logic [9:0] pos, input logic [7:0] d);
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{4{d[7]}}, d});
    if (sum < 0)              return 10'd0;
    else if (sum > MOUSE_MAX) return 10'(MOUSE_MAX);
    else                      return sum[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    regs_ack = 1'b0;
    case (state_q)
      S_IDLE: if (regs_req) state_d = S_ACK;
      S_ACK: begin
        regs_ack = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addr     = {regs_addr[7:1], 1'b0};
  assign take     = (state_q == S_IDLE) && regs_req;
  assign wr       = take && regs_we;
  assign rd       = take && !regs_we;
  assign mx_merge = merge_bytes({6'd0, mouse_x_q}, regs_wdata, regs_wstrb);
  assign my_merge = merge_bytes({6'd0, mouse_y_q}, regs_wdata, regs_wstrb);

  always_comb begin
    rd_mux = 16'd0;
    case (addr)
      REG_DSTART: rd_mux = dstart_q;
      REG_MOUSEX: rd_mux = {6'd0, mouse_x_q};
      REG_MOUSEY: rd_mux = {6'd0, mouse_y_q};
      REG_STATUS: begin
        rd_mux[ST_VBL]                 = vbl_q;
        rd_mux[ST_KRDY]                = !kbd_empty;
        rd_mux[ST_KOVF]                = kovf_q;
        rd_mux[ST_BTN_LO+2:ST_BTN_LO]  = mouse_btn;
      end
      REG_KBD:    rd_mux = kbd_empty ? 16'd0 : {8'd0, kbd_head};
      REG_INTCTL: rd_mux = {14'd0, irq_en_q};
      default:    rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dstart_q   <= 16'd0;
      mouse_x_q  <= 10'd0;
      mouse_y_q  <= 10'd0;
      irq_en_q   <= 2'b00;
      vbl_q      <= 1'b0;
      kovf_q     <= 1'b0;
      rdata_q    <= 16'd0;
      pop_pend_q <= 1'b0;
    end else begin
      if (wr && addr == REG_DSTART) dstart_q <= merge_bytes(dstart_q, regs_wdata, regs_wstrb);

      if (wr && addr == REG_MOUSEX) mouse_x_q <= mx_merge[9:0];
      else if (mouse_valid)         mouse_x_q <= mouse_step(mouse_x_q, mouse_dx);
      if (wr && addr == REG_MOUSEY) mouse_y_q <= my_merge[9:0];
      else if (mouse_valid)         mouse_y_q <= mouse_step(mouse_y_q, mouse_dy);

      if (wr && addr == REG_INTCTL && regs_wstrb[1]) irq_en_q <= regs_wdata[9:8];

      // status set events take priority over a simultaneous write-1-to-clear
      if (vblank) vbl_q <= 1'b1;
      else if (wr && addr == REG_INTCTL && regs_wstrb[0] && regs_wdata[0]) vbl_q <= 1'b0;
      if (kbd_ovf) kovf_q <= 1'b1;
      else if (wr && addr == REG_INTCTL && regs_wstrb[0] && regs_wdata[2]) kovf_q <= 1'b0;

      rdata_q    <= rd ? rd_mux : 16'd0;
      // pop in the ack cycle only if the returned byte was real
      pop_pend_q <= rd && (addr == REG_KBD) && !kbd_empty;
    end
  end

  blit_kbd_fifo #(
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (kbd_valid),
    .push_data (kbd_data),
    .pop       (pop_pend_q),
    .head      (kbd_head),
    .empty     (kbd_empty),
    .full      (kbd_full),
    .ovf       (kbd_ovf)
  );

  assign regs_rdata    = rdata_q;
  assign display_start = dstart_q;
  assign irq           = (vbl_q & irq_en_q[0]) | (!kbd_empty & irq_en_q[1]);
  assign unused_ok     = ^{regs_addr[0], mx_merge[15:10], my_merge[15:10], kbd_full};

endmodule

// File: tb/tb_blit_regs.sv
// tb/tb_blit_regs.sv - directed self-checking bench for blit_regs
// Keyboard expectations follow BLIT_REGS_KBD_FIFO_EN (FIFO of 4 or single byte).
module tb_blit_regs;
  import blit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regs_req = 1'b0;
  logic [7:0]  regs_addr = 8'd0;
  logic [15:0] regs_wdata = 16'd0;
  logic [1:0]  regs_wstrb = 2'b00;
  logic        regs_we = 1'b0;
  logic        regs_ack;
  logic [15:0] regs_rdata;
  logic        mouse_valid = 1'b0;
  logic [7:0]  mouse_dx = 8'd0, mouse_dy = 8'd0;
  logic [2:0]  mouse_btn = 3'd0;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_data = 8'd0;
  logic        vblank = 1'b0;
  logic [15:0] display_start;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic with_vbl   = 1'b0;
  logic with_mouse = 1'b0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  blit_regs #(.MOUSE_MAX(1023), .KBD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .regs_req(regs_req), .regs_addr(regs_addr),
    .regs_wdata(regs_wdata), .regs_wstrb(regs_wstrb), .regs_we(regs_we),
    .regs_ack(regs_ack), .regs_rdata(regs_rdata), .mouse_valid(mouse_valid),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_btn(mouse_btn),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .vblank(vblank),
    .display_start(display_start), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_access(input logic [7:0] a, input logic we, input logic [15:0] wd,
                            input logic [1:0] st, output logic [15:0] rdat);
    @(posedge clk); #1;
    regs_req = 1'b1; regs_addr = a; regs_we = we; regs_wdata = wd; regs_wstrb = st;
    if (with_vbl) vblank = 1'b1;
    if (with_mouse) mouse_valid = 1'b1;
    @(posedge clk); #1;
    regs_req = 1'b0; regs_we = 1'b0; vblank = 1'b0; mouse_valid = 1'b0;
    check($sformatf("ack@%0h", a), {31'd0, regs_ack}, 32'd1);
    rdat = regs_rdata;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] wd, input logic [1:0] st);
    logic [15:0] dummy;
    bus_access(a, 1'b1, wd, st, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_access(a, 1'b0, 16'd0, 2'b00, v);
    check(tag, {16'd0, v}, {16'd0, exp});
  endtask

  task automatic pulse_mouse(input logic [7:0] dx, input logic [7:0] dy);
    @(posedge clk); #1; mouse_valid = 1'b1; mouse_dx = dx; mouse_dy = dy;
    @(posedge clk); #1; mouse_valid = 1'b0;
  endtask

  task automatic push_kbd(input logic [7:0] b);
    @(posedge clk); #1; kbd_valid = 1'b1; kbd_data = b;
    @(posedge clk); #1; kbd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, regs_ack}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_dstart", {16'd0, display_start}, 32'd0);
    check("rst_rdata", {16'd0, regs_rdata}, 32'd0);
    rst_n = 1'b1;
    rd_chk("rst_status", REG_STATUS, 16'h0000);
    check("rst_irq2", {31'd0, irq}, 32'd0);

    bus_wr(REG_DSTART, 16'hABCD, 2'b10);
    rd_chk("dstart_hi", REG_DSTART, 16'hAB00);
    check("display_start", {16'd0, display_start}, 32'h0000AB00);
    bus_wr(REG_DSTART, 16'h1234, 2'b00);
    rd_chk("dstart_strb0", REG_DSTART, 16'hAB00);
    rd_chk("dstart_odd", 8'h01, 16'hAB00);

    bus_wr(REG_MOUSEX, 16'd5, 2'b11);
    pulse_mouse(8'hF6, 8'h00);
    rd_chk("mx_sat_lo", REG_MOUSEX, 16'd0);
    bus_wr(REG_MOUSEY, 16'd1020, 2'b11);
    pulse_mouse(8'h00, 8'h07);
    rd_chk("my_sat_hi", REG_MOUSEY, 16'd1023);
    bus_wr(REG_MOUSEX, 16'd100, 2'b11);
    pulse_mouse(8'h03, 8'h00);
    rd_chk("mx_add", REG_MOUSEX, 16'd103);
    mouse_dx = 8'h05; mouse_dy = 8'hFD;
    with_mouse = 1'b1;
    bus_wr(REG_MOUSEX, 16'd50, 2'b11);
    with_mouse = 1'b0;
    rd_chk("mx_cpu_wins", REG_MOUSEX, 16'd50);
    rd_chk("my_delta", REG_MOUSEY, 16'd1020);

    push_kbd(8'h11); push_kbd(8'h22); push_kbd(8'h33); push_kbd(8'h44); push_kbd(8'h55);
    rd_chk("status_ovf", REG_STATUS, 16'h0006);
`ifdef BLIT_REGS_KBD_FIFO_EN
    rd_chk("kbd0", REG_KBD, 16'h0011);
    rd_chk("kbd1", REG_KBD, 16'h0022);
    rd_chk("kbd2", REG_KBD, 16'h0033);
    rd_chk("kbd3", REG_KBD, 16'h0044);
`else
    rd_chk("kbd0", REG_KBD, 16'h0055);
`endif
    rd_chk("kbd_empty", REG_KBD, 16'h0000);
    rd_chk("status_drained", REG_STATUS, 16'h0004);
    bus_wr(REG_INTCTL, 16'h0004, 2'b01);
    rd_chk("status_kovf_clr", REG_STATUS, 16'h0000);

    bus_wr(REG_INTCTL, 16'h0100, 2'b10);
    @(posedge clk); #1; vblank = 1'b1;
    @(posedge clk); #1; vblank = 1'b0;
    check("irq_vbl", {31'd0, irq}, 32'd1);
    rd_chk("status_vbl", REG_STATUS, 16'h0001);
    rd_chk("intctl_mask", REG_INTCTL, 16'h0001);
    with_vbl = 1'b1;
    bus_wr(REG_INTCTL, 16'h0001, 2'b01);
    with_vbl = 1'b0;
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    rd_chk("status_set_wins", REG_STATUS, 16'h0001);
    bus_wr(REG_INTCTL, 16'h0001, 2'b01);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    mouse_btn = 3'b101;
    rd_chk("status_btn", REG_STATUS, 16'h0050);
    mouse_btn = 3'b000;

    bus_wr(REG_INTCTL, 16'h0200, 2'b10);
    check("irq_krdy_idle", {31'd0, irq}, 32'd0);
    push_kbd(8'h77);
    check("irq_krdy", {31'd0, irq}, 32'd1);
    rd_chk("kbd_77", REG_KBD, 16'h0077);
    @(posedge clk); #1;
    check("irq_krdy_pop", {31'd0, irq}, 32'd0);

    rd_chk("unmapped_rd", 8'h0E, 16'h0000);
    rd_chk("reg0c_rd", 8'h0C, 16'h0000);
    bus_wr(8'h0E, 16'hFFFF, 2'b11);
    rd_chk("unmapped_dstart", REG_DSTART, 16'hAB00);
    rd_chk("unmapped_mx", REG_MOUSEX, 16'd50);
    rd_chk("unmapped_intctl", REG_INTCTL, 16'h0002);

    @(posedge clk); #1;
    regs_req = 1'b1; regs_addr = REG_STATUS; regs_we = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    regs_req = 1'b0; rst_n = 1'b1;
    check("rst_cancels_ack", {31'd0, regs_ack}, 32'd0);
    check("rst_mid_dstart", {16'd0, display_start}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
